// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller and the score logic.
// Segment patterns are active-low for a common-anode display.
package ssd_pkg;

    localparam int unsigned SEG_W_STD = 8;
    localparam logic [SEG_W_STD-1:0] SEG_BLANK = '1;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } scan_state_t;

    // Hex digit to segment pattern, decimal point off (bit 7 = dp, bit 0 = a).
    localparam logic [SEG_W_STD-1:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [SEG_W_STD-1:0] hex_to_seg(input logic [3:0] value);
        return HEX_SEG[value];
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Bus between the score logic (master) and the scan controller (slave).
// Optional macro SSD_SCAN_DIM_EN adds the bright input.
interface ssd_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SEG_W      = 8
);
    logic [NUM_DIGITS*SEG_W-1:0] digits;
    logic [NUM_DIGITS-1:0]       digit_en;
    logic                        load;
`ifdef SSD_SCAN_DIM_EN
    logic [2:0]                  bright;
`endif
    logic [NUM_DIGITS-1:0]       ctl;
    logic [SEG_W-1:0]            ssd_out;
    logic                        frame_done;

    modport master (
        output digits, digit_en, load,
`ifdef SSD_SCAN_DIM_EN
        output bright,
`endif
        input  ctl, ssd_out, frame_done
    );

    modport slave (
        input  digits, digit_en, load,
`ifdef SSD_SCAN_DIM_EN
        input  bright,
`endif
        output ctl, ssd_out, frame_done
    );
endinterface

// File: rtl/ssd_frame_buf.sv
// Pending/active double buffer: loads land in pending, the frame boundary promotes them.
// With SSD_SCAN_DIM_EN defined, brightness is sampled at the boundary as well.
module ssd_frame_buf
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SEG_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        boundary,
    input  logic [NUM_DIGITS*SEG_W-1:0] new_digits,
    input  logic [NUM_DIGITS-1:0]       new_en,
`ifdef SSD_SCAN_DIM_EN
    input  logic [2:0]                  new_bright,
    output logic [2:0]                  active_bright,
`endif
    output logic [NUM_DIGITS*SEG_W-1:0] active_digits,
    output logic [NUM_DIGITS-1:0]       active_en
);

    logic [NUM_DIGITS*SEG_W-1:0] pending_digits;
    logic [NUM_DIGITS-1:0]       pending_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_digits <= '1;
            pending_en     <= '0;
            active_digits  <= '1;
            active_en      <= '0;
`ifdef SSD_SCAN_DIM_EN
            active_bright  <= 3'd7;
`endif
        end else begin
            if (load) begin
                pending_digits <= new_digits;
                pending_en     <= new_en;
            end
            // A load on the boundary bypasses pending so it shows without a frame of lag.
            if (boundary) begin
                active_digits <= load ? new_digits : pending_digits;
                active_en     <= load ? new_en     : pending_en;
`ifdef SSD_SCAN_DIM_EN
                active_bright <= new_bright;
`endif
            end
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Self-timed common-anode seven-segment scan mux with blanking guard and double-buffered frame.
// Optional macro SSD_SCAN_DIM_EN adds PWM dimming via bright[2:0].
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SEG_W        = 8,
    parameter int unsigned DRIVE_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    ssd_scan_ctrl_if.slave   bus
);

    localparam int unsigned MAX_CYC  = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             boundary;
    logic             lit;

    logic [NUM_DIGITS*SEG_W-1:0] active_digits;
    logic [NUM_DIGITS-1:0]       active_en;
`ifdef SSD_SCAN_DIM_EN
    logic [2:0]                  active_bright;
    logic [31:0]                 lit_limit;
`endif

    assign boundary = (state == ST_DRIVE) && (idx == '0) && (cnt == DRIVE_LAST);

    ssd_frame_buf #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEG_W      (SEG_W)
    ) u_frame_buf (
        .clk           (clk),
        .rst           (rst),
        .load          (bus.load),
        .boundary      (boundary),
        .new_digits    (bus.digits),
        .new_en        (bus.digit_en),
`ifdef SSD_SCAN_DIM_EN
        .new_bright    (bus.bright),
        .active_bright (active_bright),
`endif
        .active_digits (active_digits),
        .active_en     (active_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BLANK;
            idx   <= LAST_IDX;
            cnt   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt + CNT_W'(1);
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = ST_DRIVE;
                    cnt_next   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    idx_next   = (idx == '0) ? LAST_IDX : idx - IDX_W'(1);
                end
            end
            default: begin
                state_next = ST_BLANK;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef SSD_SCAN_DIM_EN
    // Lit window is (bright+1)/8 of the drive slot; bright=7 covers it fully.
    assign lit_limit = ((32'(active_bright) + 32'd1) * 32'(DRIVE_CYCLES)) >> 3;
    assign lit       = 32'(cnt) < lit_limit;
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        bus.ctl        = '1;
        bus.ssd_out    = '1;
        bus.frame_done = boundary;
        if (state == ST_DRIVE && lit) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (idx == IDX_W'(k) && active_en[k]) begin
                    bus.ctl[k]  = 1'b0;
                    bus.ssd_out = active_digits[k*SEG_W +: SEG_W];
                end
            end
        end
    end

endmodule
